// File: rtl/fetch_unit_if.sv
// +----------------------------------------------------------------------------+
// | fetch_unit_if: program-memory read bus (req/ack) between fetch and memory.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface fetch_unit_if #(
    parameter int PC_W = 16
) ();
    logic            pm_req;
    logic [PC_W-1:0] pm_addr;
    logic            pm_ack;
    logic [15:0]     pm_rdata;

    modport master (output pm_req, output pm_addr, input pm_ack, input pm_rdata);
    modport slave  (input pm_req, input pm_addr, output pm_ack, output pm_rdata);
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// +----------------------------------------------------------------------------+
// | fetch_unit: AVR instruction fetch, PC owner, two-word opcode assembly.     |
// | Optional macro FETCH_TWO_WORD_EN enables 32-bit opcode fetch.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_unit #(
    parameter int              PC_W         = 16,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            en_PM,
    input  wire logic            en_Fetch,
    input  wire logic            pc_load,
    input  wire logic [PC_W-1:0] pc_target,
    fetch_unit_if.master         pm,
    output logic [15:0]          instr,
    output logic [15:0]          instr_ext,
    output logic                 is_two_word,
    output logic                 instr_valid,
    output logic [PC_W-1:0]      pc_out,
    output logic                 fetch_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ1 = 2'd1,
        REQ2 = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] c_PC_ONE = PC_W'(1);
    localparam logic [PC_W-1:0] c_PC_TWO = PC_W'(2);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_addr;
    logic [PC_W-1:0] r_load_target;
    logic            r_req;
    logic            r_fetch_pend;
    logic            r_load_pend;
    logic            r_two_cap;
    logic [15:0]     r_word1;
    logic [15:0]     r_word2;
    logic [15:0]     r_instr;
    logic [15:0]     r_instr_ext;
    logic            r_two;
    logic            r_valid;

    logic            w_two_word_op;
    logic            w_do_fetch;
    logic            w_do_load;
    logic [PC_W-1:0] w_load_tgt;

`ifdef FETCH_TWO_WORD_EN
    // LDS/STS share 1001_00xx_xxxx_0000; JMP/CALL share 1001_010x_xxxx_11xx
    assign w_two_word_op = ((pm.pm_rdata[15:10] == 6'b100100)  && (pm.pm_rdata[3:0] == 4'b0000)) ||
                           ((pm.pm_rdata[15:9]  == 7'b1001010) && (pm.pm_rdata[3:2] == 2'b11));
`else
    assign w_two_word_op = 1'b0;
`endif

    // A same-cycle strobe counts as much as one recorded earlier in the transaction
    assign w_do_fetch = en_Fetch | r_fetch_pend;
    assign w_do_load  = pc_load  | r_load_pend;
    assign w_load_tgt = pc_load ? pc_target : r_load_target;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_pc          <= RESET_VECTOR;
            r_addr        <= RESET_VECTOR;
            r_load_target <= RESET_VECTOR;
            r_req         <= 1'b0;
            r_fetch_pend  <= 1'b0;
            r_load_pend   <= 1'b0;
            r_two_cap     <= 1'b0;
            r_word1       <= 16'h0000;
            r_word2       <= 16'h0000;
            r_instr       <= 16'h0000;
            r_instr_ext   <= 16'h0000;
            r_two         <= 1'b0;
            r_valid       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (pc_load) begin
                        r_pc    <= pc_target;
                        r_valid <= 1'b0;
                    end
                    if (en_PM) begin
                        r_state      <= REQ1;
                        r_req        <= 1'b1;
                        r_addr       <= pc_load ? pc_target : r_pc;
                        r_valid      <= 1'b0;
                        r_fetch_pend <= 1'b0;
                        r_load_pend  <= 1'b0;
                    end
                end
                REQ1, REQ2: begin
                    if (pc_load) begin
                        r_load_pend   <= 1'b1;
                        r_load_target <= pc_target;
                    end
                    if (en_Fetch) begin
                        r_fetch_pend <= 1'b1;
                    end
                    if (pm.pm_ack) begin
                        if (w_do_load) begin
                            // Redirect wins: the returned word is dropped
                            r_req        <= 1'b0;
                            r_pc         <= w_load_tgt;
                            r_state      <= IDLE;
                            r_fetch_pend <= 1'b0;
                            r_load_pend  <= 1'b0;
                        end else if (r_state == REQ1 && w_two_word_op) begin
                            r_word1   <= pm.pm_rdata;
                            r_two_cap <= 1'b1;
                            r_addr    <= r_addr + c_PC_ONE;
                            r_state   <= REQ2;
                        end else begin
                            r_req <= 1'b0;
                            if (r_state == REQ1) begin
                                r_word1   <= pm.pm_rdata;
                                r_two_cap <= 1'b0;
                            end else begin
                                r_word2 <= pm.pm_rdata;
                            end
                            if (w_do_fetch) begin
                                r_instr      <= (r_state == REQ1) ? pm.pm_rdata : r_word1;
                                r_instr_ext  <= (r_state == REQ1) ? 16'h0000 : pm.pm_rdata;
                                r_two        <= (r_state == REQ2);
                                r_valid      <= 1'b1;
                                r_pc         <= r_pc + ((r_state == REQ2) ? c_PC_TWO : c_PC_ONE);
                                r_fetch_pend <= 1'b0;
                                r_state      <= IDLE;
                            end else begin
                                r_state <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (pc_load) begin
                        r_pc    <= pc_target;
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end else if (en_Fetch) begin
                        r_instr     <= r_word1;
                        r_instr_ext <= r_two_cap ? r_word2 : 16'h0000;
                        r_two       <= r_two_cap;
                        r_valid     <= 1'b1;
                        r_pc        <= r_pc + (r_two_cap ? c_PC_TWO : c_PC_ONE);
                        r_state     <= IDLE;
                    end
                    r_fetch_pend <= 1'b0;
                    r_load_pend  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign pm.pm_req   = r_req;
    assign pm.pm_addr  = r_addr;
    assign instr       = r_instr;
    assign instr_ext   = r_instr_ext;
    assign is_two_word = r_two;
    assign instr_valid = r_valid;
    assign pc_out      = r_pc;
    // HOLD is only ever occupied while a commit is still owed
    assign fetch_busy  = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | tb_fetch_unit: randomized scoreboard bench for fetch_unit with a wait-     |
// | stated memory responder and a word-level reference model.  Rev 1.0        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_unit;
    localparam int PC_W = 16;
`ifdef FETCH_TWO_WORD_EN
    localparam bit TWO = 1'b1;
`else
    localparam bit TWO = 1'b0;
`endif

    typedef struct {
        logic [15:0] i;
        logic [15:0] e;
        logic        tw;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en_PM = 1'b0;
    logic        en_Fetch = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_target = 16'h0000;
    logic [15:0] instr, instr_ext, pc_out;
    logic        is_two_word, instr_valid, fetch_busy;

    fetch_unit_if #(.PC_W(PC_W)) pmb ();

    fetch_unit #(.PC_W(PC_W), .RESET_VECTOR(16'h0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .en_PM      (en_PM),
        .en_Fetch   (en_Fetch),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .pm         (pmb),
        .instr      (instr),
        .instr_ext  (instr_ext),
        .is_two_word(is_two_word),
        .instr_valid(instr_valid),
        .pc_out     (pc_out),
        .fetch_busy (fetch_busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [15:0] addr_q[$];
    logic [15:0] mem[0:65535];
    int          wait_cfg = 0;
    bit          spur = 1'b0;
    logic [15:0] mpc = 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic bit is_two(input logic [15:0] w);
        if (!TWO) return 1'b0;
        return ((w ==? 16'b1001_000?_????_0000) === 1'b1) ||   // LDS
               ((w ==? 16'b1001_001?_????_0000) === 1'b1) ||   // STS
               ((w ==? 16'b1001_010?_????_110?) === 1'b1) ||   // JMP
               ((w ==? 16'b1001_010?_????_111?) === 1'b1);     // CALL
    endfunction

    // Memory responder: acks after wait_cfg wait cycles, checks each read address
    initial begin
        int cnt;
        cnt = 0;
        pmb.pm_ack   = 1'b0;
        pmb.pm_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (spur) begin
                pmb.pm_ack   = 1'b1;
                pmb.pm_rdata = 16'h9000;
                spur         = 1'b0;
            end else if (pmb.pm_req && cnt >= wait_cfg) begin
                pmb.pm_ack   = 1'b1;
                pmb.pm_rdata = mem[pmb.pm_addr];
                cnt          = 0;
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pm_read: unexpected read at %0h, required none", pmb.pm_addr);
                end else begin
                    check("pm_addr", 32'(pmb.pm_addr), 32'(addr_q.pop_front()));
                end
            end else if (pmb.pm_req) begin
                pmb.pm_ack   = 1'b0;
                pmb.pm_rdata = 16'($urandom);
                cnt++;
            end else begin
                pmb.pm_ack = 1'b0;
                cnt        = 0;
            end
        end
    end

    // Commit monitor: every rising instr_valid is one committed instruction
    initial begin
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && instr_valid && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL commit: unexpected commit instr %0h, required none", instr);
                end else begin
                    e = exp_q.pop_front();
                    check("instr", 32'(instr), 32'(e.i));
                    check("instr_ext", 32'(instr_ext), 32'(e.e));
                    check("is_two_word", 32'(is_two_word), 32'(e.tw));
                    check("pc_commit", 32'(pc_out), 32'(e.pc));
                end
            end
            prev = instr_valid;
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (fetch_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check(name, 32'(fetch_busy), 32'h0);
    endtask

    // One fetch; en_Fetch pulsed 'delay' cycles after the first request cycle
    task automatic fetch(input int waits, input int delay, input bit noise);
        exp_t e;
        int   k, busy_cnt, req_cycles, commit_cyc;
        bit   done;
        wait_cfg = waits;
        e.i  = mem[mpc];
        e.tw = is_two(e.i);
        addr_q.push_back(mpc);
        if (e.tw) begin
            addr_q.push_back(mpc + 16'd1);
            e.e = mem[mpc + 16'd1];
        end else begin
            e.e = 16'h0000;
        end
        mpc  = mpc + (e.tw ? 16'd2 : 16'd1);
        e.pc = mpc;
        exp_q.push_back(e);
        req_cycles = (waits + 1) * (e.tw ? 2 : 1);
        commit_cyc = (req_cycles > delay + 1) ? req_cycles : delay + 1;
        @(negedge clk);
        en_PM = 1'b1;
        @(negedge clk);
        en_PM    = 1'b0;
        k        = 0;
        busy_cnt = 0;
        done     = 1'b0;
        while (!done && k < 300) begin
            if (fetch_busy) busy_cnt++;
            else if (k > delay) done = 1'b1;
            en_Fetch = (k == delay);
            en_PM    = (k == delay) && noise;
            if (!done) @(negedge clk);
            k++;
        end
        en_Fetch = 1'b0;
        en_PM    = 1'b0;
        if (!done) check("fetch_timeout", 32'(fetch_busy), 32'h0);
        check("busy_cycles", 32'(busy_cnt), 32'(commit_cyc));
    endtask

    task automatic load_in_req(input int waits, input logic [15:0] tgt);
        wait_cfg = waits;
        addr_q.push_back(mpc);
        @(negedge clk);
        en_PM = 1'b1;
        @(negedge clk);
        en_PM     = 1'b0;
        pc_load   = 1'b1;
        pc_target = tgt;
        @(negedge clk);
        pc_load = 1'b0;
        wait_idle("load_timeout");
        mpc = tgt;
        check("pc_after_redirect", 32'(pc_out), 32'(tgt));
        check("valid_after_redirect", 32'(instr_valid), 32'h0);
    endtask

    task automatic set_pc(input logic [15:0] tgt);
        @(negedge clk);
        pc_load   = 1'b1;
        pc_target = tgt;
        @(negedge clk);
        pc_load = 1'b0;
        mpc     = tgt;
        check("pc_set", 32'(pc_out), 32'(tgt));
        check("valid_after_set", 32'(instr_valid), 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        for (int a = 0; a < 65536; a++) begin
            w = 16'($urandom);
            case ($urandom_range(0, 7))
                0: begin w[15:9] = 7'b1001000; w[3:0] = 4'b0000; end
                1: begin w[15:9] = 7'b1001001; w[3:0] = 4'b0000; end
                2: begin w[15:9] = 7'b1001010; w[3:1] = 3'b110; end
                3: begin w[15:9] = 7'b1001010; w[3:1] = 3'b111; end
                default: ;
            endcase
            mem[a] = w;
        end

        repeat (2) @(negedge clk);
        check("rst_pm_req", 32'(pmb.pm_req), 32'h0);
        check("rst_pm_addr", 32'(pmb.pm_addr), 32'h0);
        check("rst_pc", 32'(pc_out), 32'h0);
        check("rst_instr", 32'(instr), 32'h0);
        check("rst_instr_ext", 32'(instr_ext), 32'h0);
        check("rst_two", 32'(is_two_word), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_busy", 32'(fetch_busy), 32'h0);
        reset = 1'b1;

        mem[16'h0000] = 16'h0C01;
        fetch(0, 0, 1'b0);

        set_pc(16'h0010);
        mem[16'h0010] = 16'h940C;
        mem[16'h0011] = 16'h0123;
        fetch(2, 3, 1'b0);

        mem[mpc] = 16'h0000;
        fetch(3, 1, 1'b0);

        load_in_req(1, 16'h0200);
        fetch(0, 0, 1'b0);

        set_pc(16'hFFFF);
        mem[16'hFFFF] = 16'h9000;
        mem[16'h0000] = 16'h1234;
        fetch(1, 0, 1'b0);

        // Asynchronous reset in the middle of a wait-stated request
        wait_cfg = 20;
        @(negedge clk);
        en_PM = 1'b1;
        @(negedge clk);
        en_PM = 1'b0;
        check("req_before_reset", 32'(pmb.pm_req), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("req_in_reset", 32'(pmb.pm_req), 32'h0);
        check("pc_in_reset", 32'(pc_out), 32'h0);
        check("busy_in_reset", 32'(fetch_busy), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        mpc   = 16'h0000;
        spur  = 1'b1;
        repeat (3) @(negedge clk);
        check("busy_after_spur_ack", 32'(fetch_busy), 32'h0);
        check("valid_after_spur_ack", 32'(instr_valid), 32'h0);
        check("pc_after_spur_ack", 32'(pc_out), 32'h0);

        repeat (40) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5, 6:
                    fetch($urandom_range(0, 3), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
                7, 8:
                    load_in_req($urandom_range(0, 3), 16'($urandom));
                default:
                    set_pc(16'($urandom));
            endcase
        end

        repeat (4) @(negedge clk);
        check("commits_outstanding", 32'(exp_q.size()), 32'h0);
        check("reads_outstanding", 32'(addr_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch responder for the AVR-based core. Consumes the `en_PM` / `en_Fetch` stage strobes issued by the core's stage sequencer and owns the program counter. Runs a req/ack read transaction to program memory, detects AVR 32-bit (two-word) opcodes, and presents a committed instruction to decode. Reports `fetch_busy` back so the sequencer can stall on wait-stated memory.

## Interface
- `PC_W`, 16, program counter / word-address width
- `RESET_VECTOR`, 0, PC value after reset
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `en_PM`  in  1  start program-memory read at current PC
- `en_Fetch`  in  1  commit fetched word(s) to instruction outputs, advance PC
- `pc_load`  in  1  load `pc_target` into PC (branch/jump from execute)
- `pc_target`  in  PC_W  jump destination (word address)
- `pm_req`  out  1  program-memory read request
- `pm_addr`  out  PC_W  read word address
- `pm_ack`  in  1  read data valid this cycle
- `pm_rdata`  in  16  read data
- `instr`  out  16  committed first instruction word
- `instr_ext`  out  16  committed second word (two-word ops), else 0
- `is_two_word`  out  1  committed instruction is 32-bit
- `instr_valid`  out  1  `instr`/`instr_ext` hold a committed instruction
- `pc_out`  out  PC_W  current PC (address of next instruction to fetch)
- `fetch_busy`  out  1  memory transaction in progress or commit pending

## Operation
- States: IDLE, REQ1, REQ2, HOLD.
- IDLE: `en_PM`=1 → REQ1, `pm_addr`=PC (or `pc_target` if `pc_load` same cycle; PC also loaded), clear `instr_valid`.
- REQ1: `pm_req`=1, `pm_addr` stable until `pm_ack`. On ack, capture word1. If two-word opcode → REQ2 at PC+1; else → HOLD.
- Two-word opcodes: LDS `1001_000x_xxxx_0000`, STS `1001_001x_xxxx_0000`, JMP `1001_010x_xxxx_110x`, CALL `1001_010x_xxxx_111x`.
- REQ2: as REQ1 for word2; on ack → HOLD.
- HOLD: `en_Fetch`=1 → drive `instr`, `instr_ext`, `is_two_word`, set `instr_valid`, PC += 1 or 2, → IDLE.
- `en_Fetch` seen in REQ1/REQ2: recorded as pending; commit happens on the cycle HOLD is entered (HOLD bypassed).
- `en_PM` outside IDLE: ignored.
- `pc_load` in IDLE/HOLD: PC ← `pc_target`; `instr_valid` cleared. In HOLD, the captured word is discarded, → IDLE.
- `pc_load` in REQ1/REQ2: target saved as pending. Transaction runs to `pm_ack`, data discarded, no commit, PC ← saved target, → IDLE.
- PC arithmetic modulo 2^PC_W: PC+1/PC+2 wrap past all-ones. Second-word address wraps likewise.
- `fetch_busy` = state ∈ {REQ1, REQ2} or (HOLD and no commit yet).

## Timing
- Reset values: PC = `RESET_VECTOR`, state IDLE, `pm_req`=0, `pm_addr`=`RESET_VECTOR`, `instr`=0, `instr_ext`=0, `is_two_word`=0, `instr_valid`=0, `fetch_busy`=0.
- Reset is asynchronous. Assertion mid-transaction drops `pm_req` immediately; a late `pm_ack` after release is ignored in IDLE.
- `pm_req` rises the cycle after `en_PM` is sampled. With zero-wait memory (ack same cycle as req), a one-word fetch reaches HOLD 2 cycles after `en_PM`; two-word fetch, 3 cycles.
- Each wait cycle (req=1, ack=0) adds one cycle. `pm_rdata` is sampled only on ack.
- Commit outputs and PC update appear the cycle after the `en_Fetch` edge (or after the final ack when `en_Fetch` is pending).
- `pc_load` has priority over `en_Fetch` in the same cycle.

## Configuration
- `FETCH_TWO_WORD_EN` defined: two-word detection, REQ2 and PC+2 active.
- Not defined: every opcode is single-word. REQ2 unreachable, `is_two_word`=0, `instr_ext`=0, PC always +1.

## Test plan
- Reset → PC=0, all outputs 0. `en_PM` with zero-wait memory returning 0x0C01 at addr 0, then `en_Fetch` → `instr`=0x0C01, `is_two_word`=0, `instr_valid`=1, PC=1.
- PC=0x0010, memory returns 0x940C then 0x0123 (JMP), 2 wait states each → `pm_addr` 0x0010 then 0x0011. After `en_Fetch`: `instr_ext`=0x0123, `is_two_word`=1, PC=0x0012. Without macro: PC=0x0011, `is_two_word`=0.
- `en_Fetch` pulsed during a 3-wait-state REQ1 → commit on the final ack, `fetch_busy` falls the cycle after.
- `pc_load` with target 0x0200 during REQ1 → ack data discarded, `instr_valid` stays 0, PC=0x0200. Next fetch `pm_addr`=0x0200.
- PC=0xFFFF, two-word opcode → second read at 0x0000, PC after commit = 0x0001.
- `reset` asserted low while `pm_req`=1 → `pm_req`=0 same cycle, PC=`RESET_VECTOR`, state IDLE.
